loadstore: RTL and testbench

- Load/store stage of the ECAP5-DPROC pipeline, between execute and writeback.
- Converts execute-stage memory operations into single pipelined Wishbone B4 master transactions on the data port (port 2) of the memory arbiter.
- Handles byte-lane steering, load sign/zero extension and pipeline backpressure.
- Non-memory operations pass straight through to writeback in one cycle.

---
 rtl/ecap5_dproc_pkg.sv | 67 ++++++
 rtl/loadstore.sv | 197 +++++++++++++++++++
 tb/tb_loadstore.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared types and lane helpers for the ECAP5-DPROC load/store stage.
package ecap5_dproc_pkg;

    // Access size encoding carried from execute.
    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } ls_size_e;

    // Load/store sequencing states.
    typedef enum logic [1:0] {
        LS_IDLE     = 2'b00,
        LS_REQUEST  = 2'b01,
        LS_WAIT_ACK = 2'b10
    } ls_state_e;

    // Byte selects and steered write data for one store beat.
    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] dat;
    } ls_store_t;

    // Place store data on the lanes addressed by the low address bits.
    // Half accesses ignore offset[0]; word accesses ignore both bits.
    function automatic ls_store_t store_align(input ls_size_e size,
                                              input logic [1:0] offset,
                                              input logic [31:0] data);
        ls_store_t r;
        r.sel = 4'b1111;
        r.dat = data;
        case (size)
            LS_BYTE: begin
                r.sel = 4'b0001 << offset;
                r.dat = {24'h000000, data[7:0]} << {offset, 3'b000};
            end
            LS_HALF: begin
                r.sel = offset[1] ? 4'b1100 : 4'b0011;
                r.dat = offset[1] ? {data[15:0], 16'h0000} : {16'h0000, data[15:0]};
            end
            default: begin
                r.sel = 4'b1111;
                r.dat = data;
            end
        endcase
        return r;
    endfunction

    // Pull the addressed lane out of a read beat and sign/zero extend it.
    function automatic logic [31:0] load_extract(input ls_size_e size,
                                                 input logic is_unsigned,
                                                 input logic [1:0] offset,
                                                 input logic [31:0] data);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] r;
        byte_sh = data >> {offset, 3'b000};
        half_sh = data >> {offset[1], 4'b0000};
        case (size)
            LS_BYTE: r = {{24{~is_unsigned & byte_sh[7]}}, byte_sh[7:0]};
            LS_HALF: r = {{16{~is_unsigned & half_sh[15]}}, half_sh[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/loadstore.sv
// Load/store stage: turns execute memory ops into single pipelined
// Wishbone B4 transactions and forwards results to writeback.
module loadstore (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic        enable_i,
    input  logic        write_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] address_i,
    input  logic [31:0] data_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    output logic        output_valid_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i
);
    import ecap5_dproc_pkg::*;

    ls_state_e   state_q, state_d;

    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  sel_q, sel_d;

    // Operation attributes held for the response phase.
    ls_size_e    size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  offset_q, offset_d;
    logic        lat_reg_write_q, lat_reg_write_d;
    logic [4:0]  lat_reg_addr_q, lat_reg_addr_d;

    logic        out_valid_q, out_valid_d;
    logic        out_reg_write_q, out_reg_write_d;
    logic [4:0]  out_reg_addr_q, out_reg_addr_d;
    logic [31:0] out_reg_data_q, out_reg_data_d;

    ls_store_t   align;
    logic [31:0] load_data;
    logic        accept;
    logic        complete;

    assign align     = store_align(ls_size_e'(size_i), address_i[1:0], data_i);
    assign load_data = load_extract(size_q, unsigned_q, offset_q, wb_dat_i);

    assign input_ready_o = (state_q == LS_IDLE);
    assign accept        = input_valid_i && input_ready_o;

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = wdat_q;
    assign wb_sel_o = sel_q;

    assign output_valid_o = out_valid_q;
    assign reg_write_o    = out_reg_write_q;
    assign reg_addr_o     = out_reg_addr_q;
    assign reg_data_o     = out_reg_data_q;

    // Next-state, bus request and writeback result selection.
    always_comb begin
        state_d         = state_q;
        cyc_d           = cyc_q;
        stb_d           = stb_q;
        we_d            = we_q;
        adr_d           = adr_q;
        wdat_d          = wdat_q;
        sel_d           = sel_q;
        size_d          = size_q;
        unsigned_d      = unsigned_q;
        offset_d        = offset_q;
        lat_reg_write_d = lat_reg_write_q;
        lat_reg_addr_d  = lat_reg_addr_q;
        out_valid_d     = 1'b0;
        out_reg_write_d = out_reg_write_q;
        out_reg_addr_d  = out_reg_addr_q;
        out_reg_data_d  = out_reg_data_q;
        complete        = 1'b0;

        case (state_q)
            LS_IDLE: begin
                if (accept) begin
                    if (!enable_i) begin
                        out_valid_d     = 1'b1;
                        out_reg_write_d = reg_write_i;
                        out_reg_addr_d  = reg_addr_i;
                        out_reg_data_d  = data_i;
                    end else begin
                        cyc_d           = 1'b1;
                        stb_d           = 1'b1;
                        we_d            = write_i;
                        adr_d           = {address_i[31:2], 2'b00};
                        sel_d           = align.sel;
                        wdat_d          = align.dat;
                        size_d          = ls_size_e'(size_i);
                        unsigned_d      = unsigned_i;
                        offset_d        = address_i[1:0];
                        lat_reg_write_d = reg_write_i;
                        lat_reg_addr_d  = reg_addr_i;
                        state_d         = LS_REQUEST;
                    end
                end
            end
            LS_REQUEST: begin
                // An ack only counts once the slave has taken the request.
                if (!wb_stall_i) begin
                    stb_d = 1'b0;
                    if (wb_ack_i) begin
                        complete = 1'b1;
                    end else begin
                        state_d = LS_WAIT_ACK;
                    end
                end
            end
            LS_WAIT_ACK: begin
                if (wb_ack_i) begin
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = LS_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase

        if (complete) begin
            cyc_d          = 1'b0;
            state_d        = LS_IDLE;
            out_valid_d    = 1'b1;
            out_reg_addr_d = lat_reg_addr_q;
            if (we_q) begin
                out_reg_write_d = 1'b0;
                out_reg_data_d  = 32'h0000_0000;
            end else begin
                out_reg_write_d = lat_reg_write_q;
                out_reg_data_d  = load_data;
            end
        end
    end

    // State and registered outputs; reset abandons any bus cycle in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q         <= LS_IDLE;
            cyc_q           <= 1'b0;
            stb_q           <= 1'b0;
            we_q            <= 1'b0;
            adr_q           <= 32'h0000_0000;
            wdat_q          <= 32'h0000_0000;
            sel_q           <= 4'b0000;
            size_q          <= LS_BYTE;
            unsigned_q      <= 1'b0;
            offset_q        <= 2'b00;
            lat_reg_write_q <= 1'b0;
            lat_reg_addr_q  <= 5'd0;
            out_valid_q     <= 1'b0;
            out_reg_write_q <= 1'b0;
            out_reg_addr_q  <= 5'd0;
            out_reg_data_q  <= 32'h0000_0000;
        end else begin
            state_q         <= state_d;
            cyc_q           <= cyc_d;
            stb_q           <= stb_d;
            we_q            <= we_d;
            adr_q           <= adr_d;
            wdat_q          <= wdat_d;
            sel_q           <= sel_d;
            size_q          <= size_d;
            unsigned_q      <= unsigned_d;
            offset_q        <= offset_d;
            lat_reg_write_q <= lat_reg_write_d;
            lat_reg_addr_q  <= lat_reg_addr_d;
            out_valid_q     <= out_valid_d;
            out_reg_write_q <= out_reg_write_d;
            out_reg_addr_q  <= out_reg_addr_d;
            out_reg_data_q  <= out_reg_data_d;
        end
    end

endmodule

// File: tb/tb_loadstore.sv
// Directed bench for the load/store stage with hand-computed expectations.
module tb_loadstore;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        input_valid_i;
    logic        input_ready_o;
    logic        enable_i;
    logic        write_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] address_i;
    logic [31:0] data_i;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic        output_valid_o;
    logic        reg_write_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_cyc_o;
    logic        wb_stall_i;

    int vec_count  = 0;
    int miss_count = 0;

    loadstore dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .input_valid_i  (input_valid_i),
        .input_ready_o  (input_ready_o),
        .enable_i       (enable_i),
        .write_i        (write_i),
        .size_i         (size_i),
        .unsigned_i     (unsigned_i),
        .address_i      (address_i),
        .data_i         (data_i),
        .reg_write_i    (reg_write_i),
        .reg_addr_i     (reg_addr_i),
        .output_valid_o (output_valid_o),
        .reg_write_o    (reg_write_o),
        .reg_addr_o     (reg_addr_o),
        .reg_data_o     (reg_data_o),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_i       (wb_dat_i),
        .wb_dat_o       (wb_dat_o),
        .wb_we_o        (wb_we_o),
        .wb_sel_o       (wb_sel_o),
        .wb_stb_o       (wb_stb_o),
        .wb_ack_i       (wb_ack_i),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stall_i     (wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miss_count++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Present one operation for a single accepting edge, then withdraw it.
    task automatic issue(input logic en, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input logic rw, input logic [4:0] ra);
        input_valid_i = 1'b1;
        enable_i      = en;
        write_i       = wr;
        size_i        = sz;
        unsigned_i    = uns;
        address_i     = adr;
        data_i        = dat;
        reg_write_i   = rw;
        reg_addr_i    = ra;
        tick();
        input_valid_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b0;
        input_valid_i = 1'b0;
        enable_i      = 1'b0;
        write_i       = 1'b0;
        size_i        = 2'b00;
        unsigned_i    = 1'b0;
        address_i     = 32'h0;
        data_i        = 32'h0;
        reg_write_i   = 1'b0;
        reg_addr_i    = 5'd0;
        wb_dat_i      = 32'h0;
        wb_ack_i      = 1'b0;
        wb_stall_i    = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;

        // Reset state
        check("rst_cyc_stb_we", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_wdat", wb_dat_o, 32'h0);
        check("rst_sel", {28'h0, wb_sel_o}, 32'h0);
        check("rst_out", {25'h0, output_valid_o, reg_write_o, reg_addr_o}, 32'h0);
        check("rst_rdata", reg_data_o, 32'h0);
        check("rst_ready", {31'h0, input_ready_o}, 32'h1);

        // Non-memory pass-through
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 1'b1, 5'd5);
        check("alu_valid_wr_addr", {25'h0, output_valid_o, reg_write_o, reg_addr_o}, {25'h0, 2'b11, 5'd5});
        check("alu_data", reg_data_o, 32'h1234_5678);
        check("alu_no_cyc", {31'h0, wb_cyc_o}, 32'h0);
        check("alu_ready", {31'h0, input_ready_o}, 32'h1);
        tick();
        check("alu_pulse_end", {31'h0, output_valid_o}, 32'h0);

        // Store byte at offset 3, two stall cycles
        wb_stall_i = 1'b1;
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 1'b1, 5'd9);
        check("sb_adr", wb_adr_o, 32'h0000_1000);
        check("sb_sel", {28'h0, wb_sel_o}, 32'h8);
        check("sb_wdat", wb_dat_o, 32'hAB00_0000);
        check("sb_cyc_stb_we", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h7);
        check("sb_not_ready", {31'h0, input_ready_o}, 32'h0);
        tick();
        check("sb_stall1_stb", {31'h0, wb_stb_o}, 32'h1);
        check("sb_stall1_adr", wb_adr_o, 32'h0000_1000);
        tick();
        check("sb_stall2_stb", {31'h0, wb_stb_o}, 32'h1);
        check("sb_stall2_wdat", wb_dat_o, 32'hAB00_0000);
        wb_stall_i = 1'b0;
        tick();
        check("sb_wait_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h2);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("sb_done_valid_wr", {30'h0, output_valid_o, reg_write_o}, 32'h2);
        check("sb_done_addr", {27'h0, reg_addr_o}, 32'd9);
        check("sb_done_data", reg_data_o, 32'h0);
        check("sb_done_cyc_ready", {30'h0, wb_cyc_o, input_ready_o}, 32'h1);
        tick();

        // Load half signed at 0x2002
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 1'b1, 5'd7);
        check("lh_sel_we", {27'h0, wb_sel_o, wb_we_o}, {27'h0, 4'b1100, 1'b0});
        check("lh_adr", wb_adr_o, 32'h0000_2000);
        tick();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h8001_1234;
        tick();
        wb_ack_i = 1'b0;
        check("lh_valid_wr_addr", {25'h0, output_valid_o, reg_write_o, reg_addr_o}, {25'h0, 2'b11, 5'd7});
        check("lh_signed_data", reg_data_o, 32'hFFFF_8001);

        // Same access unsigned, issued in the cycle output_valid_o is high
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 1'b1, 5'd8);
        check("lhu_accept_cyc", {31'h0, wb_cyc_o}, 32'h1);
        tick();
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("lhu_data", reg_data_o, 32'h0000_8001);
        check("lhu_addr", {27'h0, reg_addr_o}, 32'd8);

        // Load word, ack 4 cycles after request acceptance
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 1'b1, 5'd3);
        check("lw_req_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h3);
        check("lw_sel", {28'h0, wb_sel_o}, 32'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lw_wait_cyc_stb_rdy", {29'h0, wb_cyc_o, wb_stb_o, input_ready_o}, 32'h4);
        end
        tick();
        check("lw_wait4_cyc_stb_rdy", {29'h0, wb_cyc_o, wb_stb_o, input_ready_o}, 32'h4);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        tick();
        wb_ack_i = 1'b0;
        check("lw_valid", {31'h0, output_valid_o}, 32'h1);
        check("lw_data", reg_data_o, 32'hDEAD_BEEF);
        check("lw_ready", {31'h0, input_ready_o}, 32'h1);
        tick();

        // Load byte signed offset 1, ack together with request acceptance
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_4001, 32'h0, 1'b1, 5'd12);
        check("lb_sel", {28'h0, wb_sel_o}, 32'h2);
        check("lb_valid_early", {31'h0, output_valid_o}, 32'h0);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_F200;
        tick();
        wb_ack_i = 1'b0;
        check("lb_valid_2cyc", {31'h0, output_valid_o}, 32'h1);
        check("lb_data", reg_data_o, 32'hFFFF_FFF2);
        check("lb_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        tick();

        // Reset while waiting for ack, then a stray ack
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 1'b1, 5'd4);
        tick();
        check("rw_wait_cyc", {31'h0, wb_cyc_o}, 32'h1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        check("rw_rst_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        check("rw_rst_valid_rdy", {30'h0, output_valid_o, input_ready_o}, 32'h1);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h5555_AAAA;
        tick();
        wb_ack_i = 1'b0;
        check("rw_late_ack_valid", {31'h0, output_valid_o}, 32'h0);
        check("rw_late_ack_cyc", {31'h0, wb_cyc_o}, 32'h0);
        tick();
        check("rw_late_ack_after", {31'h0, output_valid_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
